// File: rtl/tile_write_if.sv
// Character stream and tile RAM write bus shared by the tile write controller
// and its producer/consumer side.
interface tile_write_if;
  logic        ch_valid;
  logic [6:0]  ch_data;
  logic        ch_ready;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [6:0]  ram_din;

  modport master (
    output ch_valid,
    output ch_data,
    input  ch_ready,
    input  ram_we,
    input  ram_addr,
    input  ram_din
  );

  modport slave (
    input  ch_valid,
    input  ch_data,
    output ch_ready,
    output ram_we,
    output ram_addr,
    output ram_din
  );
endinterface

// File: rtl/tile_write_ctrl.sv
// Sole writer of the text-screen tile RAM: owns the cursor, decodes the
// character stream and control codes, and sweeps the screen blank on clear.
module tile_write_ctrl #(
  parameter int unsigned MAX_X = 40,
  parameter int unsigned MAX_Y = 20,
  parameter logic [6:0]  BLANK = 7'h20
) (
  input  logic        clk,
  input  logic        reset,
  tile_write_if.slave bus,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        clr_req,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam logic [6:0] LAST_X       = 7'(MAX_X - 1);
  localparam logic [4:0] LAST_Y       = 5'(MAX_Y - 1);
  localparam logic [4:0] SWEEP_DONE_Y = 5'(MAX_Y);
  localparam logic [6:0] CH_BS        = 7'h08;
  localparam logic [6:0] CH_LF        = 7'h0A;
  localparam logic [6:0] CH_FF        = 7'h0C;
  localparam logic [6:0] CH_CR        = 7'h0D;

  state_e      state_q, state_d;
  logic        ram_we_q, ram_we_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [6:0]  ram_din_q, ram_din_d;
  logic [6:0]  cx_q, cx_d;
  logic [4:0]  cy_q, cy_d;
  logic [6:0]  sx_q, sx_d;
  logic [4:0]  sy_q, sy_d;

  logic        accept;
  logic        is_print;
  logic        x_at_end;
  logic [6:0]  adv_x;
  logic [4:0]  adv_y;
  logic [4:0]  down_y;
  logic [4:0]  up_y;
  logic [6:0]  left_x;

  assign bus.ch_ready = (state_q == ST_IDLE) && !clr_req;
  assign accept       = bus.ch_valid && bus.ch_ready;
  assign is_print     = (bus.ch_data >= 7'h20) && (bus.ch_data <= 7'h7E);

  // Neighbour positions of the cursor; advance and move-right share one wrap rule.
  assign x_at_end = (cx_q == LAST_X);
  assign down_y   = (cy_q == LAST_Y) ? 5'd0 : cy_q + 5'd1;
  assign up_y     = (cy_q == 5'd0) ? LAST_Y : cy_q - 5'd1;
  assign left_x   = (cx_q == 7'd0) ? LAST_X : cx_q - 7'd1;
  assign adv_x    = x_at_end ? 7'd0 : cx_q + 7'd1;
  assign adv_y    = x_at_end ? down_y : cy_q;

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign cur_x        = cx_q;
  assign cur_y        = cy_q;
  assign busy         = (state_q == ST_CLEAR);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: clear ends one cycle after the last sweep write so busy covers it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (sy_q == SWEEP_DONE_Y) state_d = ST_IDLE;
        else                      state_d = ST_CLEAR;
      end
      ST_IDLE: begin
        if (clr_req)                              state_d = ST_CLEAR;
        else if (accept && bus.ch_data == CH_FF)  state_d = ST_CLEAR;
        else                                      state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Output/datapath decode: priority clr_req > accepted character > move tick.
  always_comb begin
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    case (state_q)
      ST_CLEAR: begin
        if (sy_q == SWEEP_DONE_Y) begin
          cx_d = 7'd0;
          cy_d = 5'd0;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = {sy_q, sx_q};
          ram_din_d  = BLANK;
          if (sx_q == LAST_X) begin
            sx_d = 7'd0;
            sy_d = sy_q + 5'd1;
          end else begin
            sx_d = sx_q + 7'd1;
          end
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          sx_d = 7'd0;
          sy_d = 5'd0;
        end else if (accept) begin
          if (is_print) begin
            ram_we_d   = 1'b1;
            ram_addr_d = {cy_q, cx_q};
            ram_din_d  = bus.ch_data;
            cx_d       = adv_x;
            cy_d       = adv_y;
          end else begin
            case (bus.ch_data)
              CH_CR: cx_d = 7'd0;
              CH_LF: cy_d = down_y;
              CH_BS: begin
                if (cx_q != 7'd0) begin
                  ram_we_d   = 1'b1;
                  ram_addr_d = {cy_q, cx_q - 7'd1};
                  ram_din_d  = BLANK;
                  cx_d       = cx_q - 7'd1;
                end else if (cy_q != 5'd0) begin
                  ram_we_d   = 1'b1;
                  ram_addr_d = {cy_q - 5'd1, LAST_X};
                  ram_din_d  = BLANK;
                  cx_d       = LAST_X;
                  cy_d       = cy_q - 5'd1;
                end else begin
                  cx_d = cx_q;
                end
              end
              CH_FF: begin
                sx_d = 7'd0;
                sy_d = 5'd0;
              end
              default: cx_d = cx_q;
            endcase
          end
        end else if (move_up) begin
          cy_d = up_y;
        end else if (move_down) begin
          cy_d = down_y;
        end else if (move_left) begin
          cx_d = left_x;
        end else if (move_right) begin
          cx_d = adv_x;
          cy_d = adv_y;
        end else begin
          cx_d = cx_q;
        end
      end
      default: ram_we_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= 12'd0;
      ram_din_q  <= 7'd0;
      cx_q       <= 7'd0;
      cy_q       <= 5'd0;
      sx_q       <= 7'd0;
      sy_q       <= 5'd0;
    end else begin
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
    end
  end

endmodule

// File: tb/tb_tile_write_ctrl.sv
// Scoreboard bench for tile_write_ctrl: directed stimulus pushes expected RAM
// writes, a negedge monitor pops and compares every write the DUT presents.
module tb_tile_write_ctrl;

  logic       clk;
  logic       reset;
  logic       move_up, move_down, move_left, move_right, clr_req;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];
  logic [18:0] mon_exp;

  tile_write_if bus ();

  tile_write_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .clr_req    (clr_req),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every presented write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.ram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %03h din %02h, required no write",
                 bus.ram_addr, bus.ram_din);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.ram_addr, bus.ram_din} !== mon_exp) begin
          errors++;
          $display("FAIL ram_write: got addr %03h din %02h, required addr %03h din %02h",
                   bus.ram_addr, bus.ram_din, mon_exp[18:7], mon_exp[6:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cur(input string nm, input int x, input int y);
    chk({nm, "_x"}, 32'(cur_x), 32'(x));
    chk({nm, "_y"}, 32'(cur_y), 32'(y));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_we"},    32'(bus.ram_we),   32'd0);
    chk({nm, "_addr"},  32'(bus.ram_addr), 32'd0);
    chk({nm, "_din"},   32'(bus.ram_din),  32'd0);
    chk({nm, "_busy"},  32'(busy),         32'd1);
    chk({nm, "_ready"}, 32'(bus.ch_ready), 32'd0);
    chk_cur(nm, 0, 0);
  endtask

  task automatic push_w(input logic [11:0] a, input logic [6:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_clear();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 40; x++)
        push_w({5'(y), 7'(x)}, 7'h20);
  endtask

  task automatic send(input logic [6:0] c);
    bus.ch_valid = 1'b1;
    bus.ch_data  = c;
    cyc();
    bus.ch_valid = 1'b0;
  endtask

  task automatic mv(input logic u, input logic d, input logic l, input logic r);
    move_up = u; move_down = d; move_left = l; move_right = r;
    cyc();
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
  endtask

  // Counts a run of consecutive ram_we cycles; returns at the first idle cycle after it.
  task automatic wait_we_run(input int n0, output int n);
    n = n0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (bus.ram_we === 1'b1) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic clear_done(input string nm, input int n);
    chk({nm, "_len"},   32'(n),            32'd800);
    chk({nm, "_busy"},  32'(busy),         32'd0);
    chk({nm, "_ready"}, 32'(bus.ch_ready), 32'd1);
    chk_cur(nm, 0, 0);
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.ch_valid = 1'b0; bus.ch_data = 7'h00;
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    clr_req = 1'b0;
    repeat (3) cyc();
    chk_reset_vals("reset");

    push_clear();
    reset = 1'b0;
    wait_we_run(0, n);
    clear_done("reset_clear", n);

    push_w(12'h000, 7'h41);
    push_w(12'h001, 7'h42);
    chk("stream_ready", 32'(bus.ch_ready), 32'd1);
    send(7'h41);
    send(7'h42);
    cyc();
    chk_cur("stream", 2, 0);

    mv(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) mv(1'b0, 1'b0, 1'b1, 1'b0);
    chk_cur("to_corner", 39, 19);
    push_w(12'h9A7, 7'h5A);
    send(7'h5A);
    chk_cur("wrap_char", 0, 0);

    repeat (3) mv(1'b0, 1'b1, 1'b0, 1'b0);
    mv(1'b0, 1'b0, 1'b1, 1'b0);
    chk_cur("left_wrap", 39, 3);
    mv(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cur("right_wrap", 0, 4);

    repeat (3) mv(1'b1, 1'b0, 1'b0, 1'b0);
    push_w(12'h027, 7'h20);
    send(7'h08);
    chk_cur("bs_row", 39, 0);

    mv(1'b0, 1'b0, 1'b0, 1'b1);
    mv(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) mv(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cur("pre_cr", 5, 2);
    send(7'h0D);
    chk_cur("cr", 0, 2);
    send(7'h0A);
    chk_cur("lf", 0, 3);

    repeat (3) mv(1'b1, 1'b0, 1'b0, 1'b0);
    send(7'h08);
    chk_cur("bs_origin", 0, 0);

    repeat (3) mv(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) mv(1'b0, 1'b0, 1'b0, 1'b1);
    push_w(12'h183, 7'h51);
    move_up = 1'b1;
    send(7'h51);
    move_up = 1'b0;
    chk_cur("char_beats_move", 4, 3);

    repeat (4) mv(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) mv(1'b1, 1'b0, 1'b0, 1'b0);
    mv(1'b1, 1'b0, 1'b1, 1'b0);
    chk_cur("up_beats_left", 0, 19);
    send(7'h7F);
    chk_cur("del_ignored", 0, 19);

    push_clear();
    clr_req = 1'b1;
    bus.ch_valid = 1'b1;
    bus.ch_data  = 7'h58;
    #1;
    chk("clr_blocks_ready", 32'(bus.ch_ready), 32'd0);
    cyc();
    clr_req = 1'b0;
    bus.ch_valid = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_ready", 32'(bus.ch_ready), 32'd0);
    n = (bus.ram_we === 1'b1) ? 1 : 0;
    for (int i = 0; i < 1000 && n < 300; i++) begin
      cyc();
      if (bus.ram_we === 1'b1) n++;
    end
    chk("pre_reset_writes", 32'(n), 32'd300);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_clear_reset");
    exp_q.delete();
    push_clear();
    cyc();
    cyc();
    reset = 1'b0;
    wait_we_run(0, n);
    clear_done("restart_clear", n);

    push_w(12'h000, 7'h41);
    send(7'h41);
    chk_cur("pre_ff", 1, 0);
    push_clear();
    send(7'h0C);
    n = (bus.ram_we === 1'b1) ? 1 : 0;
    move_right = 1'b1;
    cyc();
    move_right = 1'b0;
    if (bus.ram_we === 1'b1) n++;
    wait_we_run(n, n);
    clear_done("ff_clear", n);

    repeat (3) cyc();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_write_ctrl.md
# tile_write_ctrl

Write-port controller for the 4096×7 tile RAM behind the 40×20 text screen. Accepts an ASCII character stream over a valid/ready handshake, along with one-cycle cursor-move ticks from the debounced buttons, and owns the cursor position. It interprets control characters and runs a full-screen clear engine. It is the only driver of the tile RAM write port (`we`, `addr_a`, `din_a`); the text generator reads `cur_x`/`cur_y` for cursor highlighting.

## Interface
- `MAX_X`, 40: columns per row.
- `MAX_Y`, 20: rows per screen.
- `BLANK`, 7'h20: code written by clear and backspace.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `ch_valid`  in  1  character available.
- `ch_data`  in  7  ASCII code.
- `ch_ready`  out  1  controller accepts the character this cycle.
- `move_up`, `move_down`, `move_left`, `move_right`  in  1 each  single-cycle debounced ticks.
- `clr_req`  in  1  request a screen clear; level-sampled in IDLE.
- `ram_we`  out  1  tile RAM write enable.
- `ram_addr`  out  12  write address, `{y[4:0], x[6:0]}`.
- `ram_din`  out  7  write data.
- `cur_x`  out  7  cursor column.
- `cur_y`  out  5  cursor row.
- `busy`  out  1  high while not in IDLE.

## Operation
- **States:** CLEAR and IDLE only. Reset forces CLEAR with the sweep counter at (0,0).
- **Reset values:** `ram_we`=0, `ram_addr`=0, `ram_din`=0, `cur_x`=0, `cur_y`=0, `busy`=1, `ch_ready`=0.
- **CLEAR:**
  - Writes `BLANK` to every cell: x runs 0..MAX_X-1 inside y 0..MAX_Y-1, one write per cycle, MAX_X·MAX_Y writes in total.
  - After the write of cell (MAX_X-1, MAX_Y-1) is issued, go to IDLE with the cursor at (0,0).
  - During CLEAR, `ch_ready`=0, and move ticks and `clr_req` are ignored and dropped.
- **IDLE:** `ch_ready` = !`clr_req` (combinational). Priority within a cycle is `clr_req` > accepted character > move tick.
  - `clr_req`=1: go to CLEAR. The sweep restarts at (0,0).
  - **Accepted character** (`ch_valid`&&`ch_ready`) is decoded by code:
    - 0x20–0x7E: write `ch_data` at the cursor, then advance. Advance means x+1; at x=MAX_X-1, go to x=0, y+1; at (MAX_X-1, MAX_Y-1), go to (0,0).
    - 0x0D (CR): x=0, no write.
    - 0x0A (LF): y+1, wrapping MAX_Y-1→0; x is unchanged; no write.
    - 0x08 (BS): step back one cell and write `BLANK` there. If x>0, the new position is x-1. If x=0 and y>0, the new position is (MAX_X-1, y-1). At (0,0), no move and no write.
    - 0x0C (FF): go to CLEAR. The character is consumed.
    - Any other code (including 0x7F): consumed, no effect.
  - **Move tick** applies only if no character is accepted in that cycle; otherwise it is dropped.
    - One move per cycle, with priority up > down > left > right.
    - Wrap-around within the axis:
      - up at y=0 → MAX_Y-1; down at MAX_Y-1 → 0.
      - left at x=0 → MAX_X-1 on the same row; right at MAX_X-1 → 0, with y+1 and wrap at MAX_Y-1 (same as advance).
    - Moves never write RAM.
- **Write coverage:** cells with x ≥ MAX_X or y ≥ MAX_Y are never written.

## Timing
- `ram_we`, `ram_addr`, `ram_din`, `cur_x`, `cur_y` and the state are all registered; `busy` is decoded from the state.
- **Character writes:** for a character accepted at edge N, `ram_we`=1 with the old cursor address is valid in the cycle after edge N. The new cursor is also visible after edge N. `ram_we` is high for exactly one cycle per write.
- **Throughput:** one character per cycle sustained; no bubbles between back-to-back printables.
- **Clear sweep:**
  - The first clear write is presented in the cycle after the first edge following reset release, or after the edge that samples `clr_req`/FF.
  - `ram_we` then stays high for MAX_X·MAX_Y consecutive cycles.
  - `busy` falls, and `ch_ready` can rise, in the cycle following the last clear write.
- **Reset:** asserting `reset` mid-clear or mid-write forces the reset values immediately (asynchronous). On release, the clear restarts from (0,0).

## Test plan
- **Reset clear:** release reset → exactly 800 consecutive `ram_we` cycles. Addresses run 0x000..0x027, 0x080..0x0A7, …, 0x980..0x9A7, all with `ram_din`=0x20. Then `busy`=0, `ch_ready`=1, cursor (0,0).
- **Stream write:** send 'A','B' back-to-back at (0,0) → writes (0x000, 0x41) and (0x001, 0x42) on consecutive cycles; cursor ends at (2,0).
- **Wrap:** cursor (39,19), send 'Z' → write (0x9A7, 0x5A); cursor becomes (0,0). Separately, cursor (39,3), `move_right` → cursor (0,4), no write.
- **Control characters:**
  - Cursor (0,1), BS → write (0x027, 0x20); cursor (39,0).
  - Cursor (5,2), CR → (0,2); then LF → (0,3); neither produces a write.
  - BS at (0,0) → no write, cursor unchanged.
- **Simultaneous events:**
  - `clr_req` and `ch_valid` in the same cycle → `ch_ready`=0, the character is not consumed, and the clear starts.
  - `ch_valid` printable together with `move_up` at (3,3) → character written at (3,3); cursor (4,3), move dropped.
  - `move_up`+`move_left` at (0,0) → cursor (0,19).
- **Reset mid-clear:** assert reset after 300 clear writes → outputs go to their reset values immediately. After release, 800 writes follow, starting again at address 0x000.
